// File: rtl/accel_store_unit.sv
// Store unit: streams the two result polynomials (c0_out then c1_out) from the
// result buffers into memory as 256-bit lines, one 64-bit beat per coefficient.
module accel_store_unit #(
  parameter int N_COEFF = 512,
  parameter int BEATS   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] base_addr,
  output logic        busy,
  output logic        done,
  output logic        buf_sel,
  output logic [8:0]  buf_idx,
  output logic        buf_rd,
  input  logic [63:0] buf_rdata,
  output logic        pmem_write,
  output logic [31:0] pmem_address,
  output logic [63:0] pmem_wdata,
  input  logic        pmem_resp,
  output logic [2:0]  fsm_state
);

  localparam int LINES = 2 * N_COEFF / BEATS;
  localparam int LW    = $clog2(LINES);
  localparam int BW    = $clog2(BEATS);
  localparam int CW    = $clog2(BEATS + 1);
  localparam int GW    = $clog2(2 * N_COEFF);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state;
  logic [LW-1:0] line;
  logic [CW-1:0] cnt;
  logic [31:0]   base_q;
  logic [63:0]   line_buf [BEATS];
  logic [GW-1:0] g;

  // Memory handshake: pmem_write (with pmem_address/pmem_wdata) is the valid side
  // and pmem_resp the ready side; a beat transfers on each cycle both are high,
  // and the request is held unchanged on every cycle pmem_resp is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      line  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_FETCH;
            line  <= '0;
            cnt   <= '0;
          end
        end
        S_FETCH: begin
          // cnt runs 0..BEATS: reads on 0..BEATS-1, captures on 1..BEATS
          if (cnt == CW'(BEATS)) begin
            state <= S_WRITE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_WRITE: begin
          if (pmem_resp) begin
            if (cnt == CW'(BEATS - 1)) begin
              state <= S_GAP;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        S_GAP: begin
          if (line == LW'(LINES - 1)) begin
            state <= S_DONE;
          end else begin
            line  <= line + LW'(1);
            state <= S_FETCH;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath registers carry no reset; their contents only matter once written.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start)
      base_q <= base_addr & 32'hFFFF_FFE0;
    if (state == S_FETCH && cnt != '0)
      line_buf[BW'(cnt - CW'(1))] <= buf_rdata;
  end

  always_comb begin
    g            = GW'(line) * GW'(BEATS) + GW'(cnt);
    busy         = (state == S_FETCH) || (state == S_WRITE) || (state == S_GAP);
    done         = (state == S_DONE);
    buf_rd       = (state == S_FETCH) && (cnt < CW'(BEATS));
    buf_sel      = buf_rd && (int'(g) >= N_COEFF);
    buf_idx      = buf_rd ? 9'(int'(g) % N_COEFF) : '0;
    pmem_write   = (state == S_WRITE);
    pmem_address = pmem_write ? base_q + (32'(line) << 5) : '0;
    pmem_wdata   = pmem_write ? line_buf[cnt[BW-1:0]] : '0;
    fsm_state    = state;
  end

endmodule

// File: tb/tb_accel_store_unit.sv
// Bench for accel_store_unit: result-buffer and memory models driven on the
// falling edge, a beat scoreboard, a table of full transfers and corner sequences.
module tb_accel_store_unit;

  localparam int N_COEFF = 512;
  localparam int BEATS   = 4;
  localparam int LINES   = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic        busy, done, buf_sel, buf_rd, pmem_write;
  logic [8:0]  buf_idx;
  logic [63:0] buf_rdata = '0;
  logic [31:0] pmem_address;
  logic [63:0] pmem_wdata;
  logic        pmem_resp = 1'b0;
  logic [2:0]  fsm_state;

  accel_store_unit #(.N_COEFF(N_COEFF), .BEATS(BEATS)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .buf_sel(buf_sel), .buf_idx(buf_idx),
    .buf_rd(buf_rd), .buf_rdata(buf_rdata), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] base;
    bit          rnd;
    logic [31:0] first_addr;
    logic [31:0] last_addr;
    int          cycles;
  } vec_t;

  vec_t vecs [5];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int beats = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  bit gap_due = 0;
  bit stall_prev = 0;
  bit rand_mode = 0;
  logic [31:0] first_addr = '0, last_addr = '0, hold_addr = '0;
  logic [63:0] hold_data = '0, line128_b0 = '0;
  logic        rd_pend = 1'b0, pend_sel = 1'b0;
  logic [8:0]  pend_idx = '0;
  logic [31:0] exp_addr_q [$];
  logic [63:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- buffer/memory models and scoreboard ----------------
  always @(negedge clk) begin
    logic [31:0] ea;
    logic [63:0] ed;
    cyc++;
    buf_rdata = rd_pend ? (pend_sel ? 64'h1000 + 64'(pend_idx) : 64'(pend_idx))
                        : 64'hBAD0_BAD0_BAD0_BAD0;
    rd_pend  = buf_rd;
    pend_sel = buf_sel;
    pend_idx = buf_idx;

    if (done) begin
      check("done_with_busy", busy, 1'b0);
      done_cnt++;
      done_cyc = cyc;
    end
    if (buf_rd) begin
      check("rd_state", fsm_state, 3'd1);
      check("rd_with_write", pmem_write, 1'b0);
    end
    if (gap_due) begin
      check("burst_gap", pmem_write, 1'b0);
      gap_due = 0;
    end
    if (stall_prev) begin
      check("stall_write", pmem_write, 1'b1);
      check("stall_addr", pmem_address, hold_addr);
      check("stall_data", pmem_wdata, hold_data);
    end

    pmem_resp  = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
    stall_prev = (pmem_write === 1'b1) && !pmem_resp;
    hold_addr  = pmem_address;
    hold_data  = pmem_wdata;

    if (pmem_write === 1'b1 && pmem_resp) begin
      if (exp_q.size() == 0) begin
        check("extra_beat", pmem_address, 32'hFFFF_FFFF);
      end else begin
        ea = exp_addr_q.pop_front();
        ed = exp_q.pop_front();
        check("beat_addr", pmem_address, ea);
        check("beat_data", pmem_wdata, ed);
      end
      if (acc_cnt == 0) first_addr = pmem_address;
      if (acc_cnt == 512) line128_b0 = pmem_wdata;
      last_addr = pmem_address;
      acc_cnt++;
      beats++;
      if (beats == BEATS) begin
        beats   = 0;
        gap_due = 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic arm(input vec_t v, output int s);
    logic [31:0] abase;
    int g;
    exp_addr_q.delete();
    exp_q.delete();
    abase = v.base & 32'hFFFF_FFE0;
    for (int l = 0; l < LINES; l++) begin
      for (int b = 0; b < BEATS; b++) begin
        g = l * BEATS + b;
        exp_addr_q.push_back(abase + 32'(l * 32));
        exp_q.push_back(g < N_COEFF ? 64'(g) : 64'h1000 + 64'(g - N_COEFF));
      end
    end
    acc_cnt = 0; beats = 0; gap_due = 0; stall_prev = 0;
    rand_mode = v.rnd; line128_b0 = '0; first_addr = '0; last_addr = '0;
    base_addr = v.base;
    start = 1'b1;
    s = cyc;
    @(negedge clk); #1;
    start = 1'b0;
    base_addr = 32'hDEAD_BEE0;
    check("busy_after_start", busy, 1'b1);
  endtask

  task automatic run_transfer(input vec_t v, input bit repulse);
    int s, d0;
    bit seen;
    d0 = done_cnt;
    seen = 0;
    arm(v, s);
    for (int k = 0; k < 20000 && !seen; k++) begin
      if (done_cnt != d0) begin
        seen = 1;
      end else begin
        if (repulse && (cyc == s + 5 || cyc == s + 300)) begin
          start = 1'b1;
          base_addr = 32'hABCD_0000;
        end else begin
          start = 1'b0;
        end
        @(negedge clk); #1;
      end
    end
    start = 1'b0;
    check("done_pulse_seen", 64'(seen), 1);
    if (v.cycles >= 0) check("start_to_done", 64'(done_cyc - s), 64'(v.cycles));
    check("beats_left", 64'(exp_q.size()), 0);
    check("first_addr", first_addr, v.first_addr);
    check("last_addr", last_addr, v.last_addr);
    check("line128_beat0", line128_b0, 64'h1000);
    // A start presented in the DONE cycle must not launch a new transfer
    if (repulse) start = 1'b1;
    base_addr = 32'h5555_0000;
    @(negedge clk); #1;
    start = 1'b0;
    check("idle_after_done", busy, 1'b0);
    repeat (3) begin @(negedge clk); #1; end
    check("still_idle", busy, 1'b0);
    check("single_done", 64'(done_cnt - d0), 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int s, d0;
    vecs[0] = '{32'h0000_1000, 1'b0, 32'h0000_1000, 32'h0000_2FE0, 2561};
    vecs[1] = '{32'h0000_1000, 1'b1, 32'h0000_1000, 32'h0000_2FE0, -1};
    vecs[2] = '{32'h0000_101F, 1'b0, 32'h0000_1000, 32'h0000_2FE0, 2561};
    vecs[3] = '{32'hFFFF_FF00, 1'b0, 32'hFFFF_FF00, 32'h0000_1EE0, 2561};
    vecs[4] = '{32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFE0, 32'h8000_1FC0, -1};

    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pmem_write", pmem_write, 1'b0);
    check("rst_buf_rd", buf_rd, 1'b0);
    check("rst_pmem_address", pmem_address, 32'h0);
    check("rst_pmem_wdata", pmem_wdata, 64'h0);
    check("rst_buf_idx", buf_idx, 9'h0);
    check("rst_buf_sel", buf_sel, 1'b0);
    rst = 1'b0;
    @(negedge clk); #1;

    for (int i = 0; i < 5; i++) run_transfer(vecs[i], 1'b0);

    run_transfer(vecs[0], 1'b1);

    // Reset while beat 2 of line 10 is on the bus
    d0 = done_cnt;
    arm(vecs[0], s);
    for (int k = 0; k < 5000 && acc_cnt < 43; k++) begin @(negedge clk); #1; end
    check("reached_line10_beat2", 64'(acc_cnt), 43);
    rst = 1'b1;
    @(negedge clk); #1;
    check("midrst_pmem_write", pmem_write, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_buf_rd", buf_rd, 1'b0);
    check("midrst_pmem_address", pmem_address, 32'h0);
    check("midrst_done", done, 1'b0);
    rst = 1'b0;
    repeat (4) begin @(negedge clk); #1; end
    check("midrst_no_restart", busy, 1'b0);
    check("midrst_no_done", 64'(done_cnt - d0), 0);
    run_transfer(vecs[0], 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/accel_store_unit.md
ACCEL_STORE_UNIT -- requirements
Module: accel_store_unit

Interface
REQ-001 Parameter N_COEFF, default 512, coefficients per result polynomial.
REQ-002 Parameter BEATS, default 4, 64-bit beats per 256-bit memory line.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  one-cycle request to store both result polynomials.
REQ-006 base_addr  input  32  destination byte address; bits [4:0] are ignored and treated as 0.
REQ-007 busy  output  1  high from the cycle after an accepted start until done.
REQ-008 done  output  1  one-cycle pulse after the final beat is accepted.
REQ-009 buf_sel  output  1  selects the result buffer being read: 0 = c0_out, 1 = c1_out.
REQ-010 buf_idx  output  9  coefficient index being read.
REQ-011 buf_rd  output  1  read strobe for the result buffer.
REQ-012 buf_rdata  input  64  coefficient data, valid exactly 1 cycle after buf_rd.
REQ-013 pmem_write  output  1  burst write request.
REQ-014 pmem_address  output  32  line address, 32-byte aligned.
REQ-015 pmem_wdata  output  64  current beat data.
REQ-016 pmem_resp  input  1  beat accepted by memory.

Function
REQ-017 Layout: coefficient i of c0_out goes to base+8*i; coefficient i of c1_out goes to base+8*N_COEFF+8*i; each coefficient occupies one 64-bit little-endian beat.
REQ-018 Transfer order: line 0 first, ascending; 2*N_COEFF/BEATS lines in total (256 at default parameters).
REQ-019 States: IDLE, FETCH, WRITE, GAP, DONE.
REQ-020 IDLE: busy=0 and pmem_write=0; start=1 latches base_addr (aligned), clears the line counter and enters FETCH.
REQ-021 FETCH issues BEATS consecutive buf_rd cycles for line L, indices (L*BEATS..L*BEATS+BEATS-1) mod N_COEFF, with buf_sel=(L*BEATS>=N_COEFF).
REQ-022 FETCH captures each buf_rdata one cycle after its read into a BEATS x 64 line buffer; FETCH lasts BEATS+1 cycles, then the block enters WRITE.
REQ-023 WRITE holds pmem_write=1 and pmem_address=base+32*L for the whole burst; pmem_wdata = line_buffer[beat].
REQ-024 WRITE: each cycle with pmem_resp=1 advances beat; pmem_wdata changes the cycle after resp; pmem_resp=0 stalls with all outputs held.
REQ-025 On the BEATS-th resp: pmem_write drops the next cycle and the block enters GAP for exactly 1 cycle with pmem_write=0.
REQ-026 GAP: if L is the last line, go to DONE; else increment L and return to FETCH.
REQ-027 DONE: done=1 and busy=0 for 1 cycle, then IDLE.
REQ-028 start while busy, or in the DONE cycle, is ignored; it is neither queued nor allowed to alter base_addr.
REQ-029 buf_rd=0 outside FETCH; buf_idx and buf_sel are don't-care when buf_rd=0.
REQ-030 pmem_resp while pmem_write=0 is ignored.
REQ-031 Address arithmetic is modulo 2^32; wrap past 0xFFFFFFE0 is permitted and not flagged.
REQ-032 Minimum latency per line is BEATS+1 (FETCH) + BEATS (WRITE) + 1 (GAP) = 10 cycles; minimum total from start to done is 256*10 + 1 cycles.

Reset
REQ-033 rst=1 at any clock edge forces IDLE; busy, done, pmem_write and buf_rd are 0 the following cycle; pmem_address, pmem_wdata, buf_idx and buf_sel are 0.
REQ-034 Reset mid-burst abandons the transfer without completing the line; no done pulse is produced.
REQ-035 The line buffer and latched base_addr need not be reset.

Verification
REQ-036 Memory resp every cycle, base=0x00001000, c0_out[i]=i, c1_out[i]=0x1000+i, start -> 256 bursts at 0x1000..0x2FE0; beat 0 of line 128 = 0x1000; done exactly 2561 cycles after start.
REQ-037 resp inserted randomly with 50% probability -> data identical to REQ-036; pmem_write/address/wdata stable during every stalled cycle.
REQ-038 base_addr=0x0000101F -> first line written at 0x1000 (low bits ignored).
REQ-039 start re-pulsed on cycles 5 and 300 of an active transfer -> no change in sequence; exactly one done pulse.
REQ-040 rst asserted during beat 2 of line 10 -> pmem_write=0 next cycle; a new start then restarts at line 0 with correct data.
REQ-041 Check every cycle: pmem_write low for at least 1 cycle between bursts; buf_rd never high outside FETCH; done never coincides with busy.
